solver_scheduler: RTL and testbench

- Multi-lane task dispatcher and result collector for LANES Othello endgame solver pipelines (8 contexts each).
- Buffers incoming positions in a task FIFO and hands one to a lane context whenever that lane asks for work.
- Merges per-lane solved results into a single ready/valid result stream.
- Credit-limits dispatch so lanes, which cannot stall, never overflow the result FIFO.

---
 rtl/solver_pkg.sv | 35 +++
 rtl/solver_scheduler_chk.sv | 10 +
 rtl/solver_scheduler_sync_fifo.sv | 48 ++++
 rtl/solver_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_solver_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/solver_pkg.sv
// Shared types and constants for the Othello endgame solver scheduler.
package solver_pkg;

    localparam int BOARD_W       = 64;
    localparam int RES_W         = 8;
    localparam int TASKID_W_DFLT = 16;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [BOARD_W-1:0]       player;
        logic [BOARD_W-1:0]       opponent;
        logic [TASKID_W_DFLT-1:0] taskid;
    } task_t;

    typedef struct packed {
        logic [TASKID_W_DFLT-1:0] taskid;
        logic signed [RES_W-1:0]  res;
    } result_t;

    // Saturating add used by the optional statistics counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {30'd0, b};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/solver_scheduler_chk.sv
// Protocol checker for the scheduler: the credit scheme must keep the result FIFO from overflowing.
module solver_scheduler_chk (
    input logic iCLOCK,
    input logic iRESET,
    input logic res_overflow
);

    a_no_res_overflow: assert property (@(posedge iCLOCK) disable iff (iRESET) !res_overflow);

endmodule

// File: rtl/solver_scheduler_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, extra pointer bit separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge iCLOCK) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer update.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/solver_scheduler.sv
// Task dispatcher / result collector for LANES solver pipelines.
// Optional build macro SCHED_STATS_EN adds saturating dispatch/complete/dummy counters.
module solver_scheduler
    import solver_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int TASK_DEPTH  = 16,
    parameter int RES_DEPTH   = 32,
    parameter int TASKID_W    = 16,
    parameter int INIT_CYCLES = 8
) (
    input  logic                          iCLOCK,
    input  logic                          iRESET,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BOARD_W-1:0]            in_player,
    input  logic [BOARD_W-1:0]            in_opponent,
    input  logic [TASKID_W-1:0]           in_taskid,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TASKID_W-1:0]           out_taskid,
    output logic [RES_W-1:0]              out_res,
    output logic [LANES-1:0]              lane_enable,
    input  logic [LANES-1:0]              lane_take,
    output logic [LANES-1:0]              lane_valid,
    output logic [LANES*BOARD_W-1:0]      lane_player,
    output logic [LANES*BOARD_W-1:0]      lane_opponent,
    output logic [LANES*(TASKID_W+1)-1:0] lane_tag,
    input  logic [LANES-1:0]              lane_solved,
    input  logic [LANES*(TASKID_W+1)-1:0] lane_otag,
    input  logic [LANES*RES_W-1:0]        lane_res,
    output logic [$clog2(RES_DEPTH):0]    outstanding,
    output logic                          idle
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_dispatched,
    output logic [31:0]                   stat_completed,
    output logic [31:0]                   stat_dummy
`endif
);

    localparam int TW1 = TASKID_W + 1;
    localparam int TAW = 2*BOARD_W + TASKID_W;
    localparam int RW  = TASKID_W + RES_W;
    localparam int AW  = $clog2(RES_DEPTH);
    localparam int OW  = AW + 1;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CIW = $clog2(INIT_CYCLES) + 1;

    sched_state_t   state_r;
    logic [CIW-1:0] init_cnt_r;
    logic           run_s;

    logic [TAW-1:0]      task_dout_s;
    logic                task_full_s;
    logic                task_empty_s;
    logic                task_push_s;
    logic [BOARD_W-1:0]  head_player_s;
    logic [BOARD_W-1:0]  head_opponent_s;
    logic [TASKID_W-1:0] head_taskid_s;

    logic [LW-1:0] rr_ptr_r;
    logic [LW-1:0] win_idx_s;
    logic          win_found_s;
    logic          grant_s;
    int            arb_idx;

    logic [RW-1:0]  res_mem_r [RES_DEPTH];
    logic [OW-1:0]  res_wr_ptr_r;
    logic [OW-1:0]  res_rd_ptr_r;
    logic [OW-1:0]  res_count_s;
    logic           res_empty_s;
    logic           res_pop_s;
    logic           res_overflow_s;
    logic [LANES-1:0] wr_en_s;
    logic [AW-1:0]  wr_addr_s [LANES];
    logic [OW-1:0]  wr_cnt_s;

    logic                out_valid_r;
    logic [TASKID_W-1:0] out_taskid_r;
    logic [RES_W-1:0]    out_res_r;
    logic                out_hs_s;
    logic [OW-1:0]       outstanding_r;

    assign run_s       = (state_r == S_RUN);
    assign in_ready    = run_s && !task_full_s;
    assign task_push_s = in_valid && in_ready;
    assign lane_enable = {LANES{run_s}};
    assign out_valid   = out_valid_r;
    assign out_taskid  = out_taskid_r;
    assign out_res     = out_res_r;
    assign outstanding = outstanding_r;
    assign idle        = run_s && task_empty_s && (outstanding_r == {OW{1'b0}});
    assign out_hs_s    = out_valid_r && out_ready;

    assign head_player_s   = task_dout_s[TAW-1 -: BOARD_W];
    assign head_opponent_s = task_dout_s[TASKID_W +: BOARD_W];
    assign head_taskid_s   = task_dout_s[TASKID_W-1:0];

    sync_fifo #(
        .WIDTH (TAW),
        .DEPTH (TASK_DEPTH)
    ) u_task_fifo (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .push   (task_push_s),
        .pop    (grant_s),
        .din    ({in_player, in_opponent, in_taskid}),
        .dout   (task_dout_s),
        .full   (task_full_s),
        .empty  (task_empty_s)
    );

    // Power-up sequencing: lanes stay disabled for INIT_CYCLES after reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_r    <= S_INIT;
            init_cnt_r <= {CIW{1'b0}};
        end else begin
            case (state_r)
                S_INIT: begin
                    if (init_cnt_r == CIW'(INIT_CYCLES-1)) begin
                        state_r <= S_RUN;
                    end else begin
                        init_cnt_r <= init_cnt_r + CIW'(1);
                    end
                end
                S_RUN:   state_r <= S_RUN;
                default: state_r <= S_INIT;
            endcase
        end
    end

    // Round-robin search starting at rr_ptr_r over requesting lanes.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {LW{1'b0}};
        arb_idx     = 0;
        for (int i = 0; i < LANES; i++) begin
            arb_idx = (int'(rr_ptr_r) + i) % LANES;
            if (!win_found_s && lane_take[arb_idx]) begin
                win_found_s = 1'b1;
                win_idx_s   = LW'(arb_idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
        grant_s = run_s && win_found_s && !task_empty_s && (outstanding_r < OW'(RES_DEPTH));
    end

    // Present the head task only to the granted lane; every other lane sees a dummy.
    always_comb begin
        lane_valid    = {LANES{1'b0}};
        lane_player   = {(LANES*BOARD_W){1'b0}};
        lane_opponent = {(LANES*BOARD_W){1'b0}};
        lane_tag      = {(LANES*TW1){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (grant_s && (win_idx_s == LW'(i))) begin
                lane_valid[i]                      = 1'b1;
                lane_player[i*BOARD_W +: BOARD_W]   = head_player_s;
                lane_opponent[i*BOARD_W +: BOARD_W] = head_opponent_s;
                lane_tag[i*TW1 +: TW1]              = {1'b1, head_taskid_s};
            end else begin
                lane_valid[i] = 1'b0;
            end
        end
    end

    // Arbiter pointer moves past the lane that actually received a task.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rr_ptr_r <= {LW{1'b0}};
        end else if (grant_s) begin
            rr_ptr_r <= (win_idx_s == LW'(LANES-1)) ? {LW{1'b0}} : win_idx_s + LW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Compact real solves into consecutive result slots in ascending lane order.
    always_comb begin
        wr_cnt_s = {OW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            wr_en_s[i]   = lane_solved[i] && lane_otag[i*TW1 + TASKID_W];
            wr_addr_s[i] = res_wr_ptr_r[AW-1:0] + wr_cnt_s[AW-1:0];
            if (wr_en_s[i]) begin
                wr_cnt_s = wr_cnt_s + OW'(1);
            end else begin
                wr_cnt_s = wr_cnt_s;
            end
        end
        res_count_s    = res_wr_ptr_r - res_rd_ptr_r;
        res_empty_s    = (res_wr_ptr_r == res_rd_ptr_r);
        res_pop_s      = !res_empty_s && (!out_valid_r || out_ready);
        res_overflow_s = ({1'b0, res_count_s} + {1'b0, wr_cnt_s}) > (OW+1)'(RES_DEPTH);
    end

    // Result storage write ports.
    always_ff @(posedge iCLOCK) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en_s[i]) begin
                res_mem_r[wr_addr_s[i]] <= {lane_otag[i*TW1 +: TASKID_W], lane_res[i*RES_W +: RES_W]};
            end
        end
    end

    // Result pointers and the registered output head.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            res_wr_ptr_r <= {OW{1'b0}};
            res_rd_ptr_r <= {OW{1'b0}};
            out_valid_r  <= 1'b0;
            out_taskid_r <= {TASKID_W{1'b0}};
            out_res_r    <= {RES_W{1'b0}};
        end else begin
            res_wr_ptr_r <= res_wr_ptr_r + wr_cnt_s;
            if (res_pop_s) begin
                res_rd_ptr_r                <= res_rd_ptr_r + OW'(1);
                out_valid_r                 <= 1'b1;
                {out_taskid_r, out_res_r}   <= res_mem_r[res_rd_ptr_r[AW-1:0]];
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    // Credit counter: a task holds a credit from dispatch until its result leaves.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            outstanding_r <= {OW{1'b0}};
        end else begin
            case ({grant_s, out_hs_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    solver_scheduler_chk u_chk (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .res_overflow (res_overflow_s)
    );

`ifdef SCHED_STATS_EN
    logic [2:0] take_cnt_s;
    logic [2:0] dummy_cnt_s;

    // Dummy contexts are requests that did not receive a real task.
    always_comb begin
        take_cnt_s = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            take_cnt_s = take_cnt_s + {2'b00, lane_take[i]};
        end
        dummy_cnt_s = run_s ? (take_cnt_s - {2'b00, grant_s}) : 3'd0;
    end

    // Saturating statistics.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            stat_dispatched <= 32'd0;
            stat_completed  <= 32'd0;
            stat_dummy      <= 32'd0;
        end else begin
            stat_dispatched <= sat_add32(stat_dispatched, {2'b00, grant_s});
            stat_completed  <= sat_add32(stat_completed, 3'(wr_cnt_s));
            stat_dummy      <= sat_add32(stat_dummy, dummy_cnt_s);
        end
    end
`endif

endmodule

// File: tb/tb_solver_scheduler.sv
// Directed self-checking bench for solver_scheduler (default parameters, LANES=2).
module tb_solver_scheduler;

    logic         iCLOCK = 1'b0;
    logic         iRESET = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_player = 64'd0;
    logic [63:0]  in_opponent = 64'd0;
    logic [15:0]  in_taskid = 16'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_taskid;
    logic [7:0]   out_res;
    logic [1:0]   lane_enable;
    logic [1:0]   lane_take = 2'b00;
    logic [1:0]   lane_valid;
    logic [127:0] lane_player;
    logic [127:0] lane_opponent;
    logic [33:0]  lane_tag;
    logic [1:0]   lane_solved = 2'b00;
    logic [33:0]  lane_otag = 34'd0;
    logic [15:0]  lane_res = 16'd0;
    logic [5:0]   outstanding;
    logic         idle;
`ifdef SCHED_STATS_EN
    logic [31:0]  stat_dispatched;
    logic [31:0]  stat_completed;
    logic [31:0]  stat_dummy;
`endif

    int checks = 0;
    int errors = 0;

    solver_scheduler dut (
        .iCLOCK        (iCLOCK),
        .iRESET        (iRESET),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_player     (in_player),
        .in_opponent   (in_opponent),
        .in_taskid     (in_taskid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taskid    (out_taskid),
        .out_res       (out_res),
        .lane_enable   (lane_enable),
        .lane_take     (lane_take),
        .lane_valid    (lane_valid),
        .lane_player   (lane_player),
        .lane_opponent (lane_opponent),
        .lane_tag      (lane_tag),
        .lane_solved   (lane_solved),
        .lane_otag     (lane_otag),
        .lane_res      (lane_res),
        .outstanding   (outstanding),
        .idle          (idle)
`ifdef SCHED_STATS_EN
        ,
        .stat_dispatched (stat_dispatched),
        .stat_completed  (stat_completed),
        .stat_dummy      (stat_dummy)
`endif
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #2;
    endtask

    task automatic push(input logic [15:0] id);
        in_valid    = 1'b1;
        in_taskid   = id;
        in_player   = {48'hAAAA_0000_0000, id};
        in_opponent = {48'h5555_0000_0000, id};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        int n;
        int pushed;
        int grants;
        logic [1:0]  g;
        logic [33:0] tg;

        // Reset values
        tick();
        tick();
        chk("rst_lane_enable", {62'd0, lane_enable}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outstanding", {58'd0, outstanding}, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd0);
        iRESET = 1'b0;

        // Init window length
        n = 0;
        while (lane_enable == 2'b00 && n < 20) begin
            n++;
            tick();
        end
        chk("init_cycles", 64'(n), 64'd8);
        chk("run_lane_enable", {62'd0, lane_enable}, 64'd3);
        chk("run_in_ready", {63'd0, in_ready}, 64'd1);
        chk("run_idle", {63'd0, idle}, 64'd1);

        // Round robin: both lanes request with one queued task each time
        push(16'h0007);
        lane_take = 2'b11;
        #1;
        chk("rr1_valid", {62'd0, lane_valid}, 64'd1);
        chk("rr1_tag", {30'd0, lane_tag}, {30'd0, 17'h0, 17'h10007});
        chk("rr1_player", lane_player[63:0], 64'hAAAA_0000_0000_0007);
        chk("rr1_opponent", lane_opponent[63:0], 64'h5555_0000_0000_0007);
        tick();
        lane_take = 2'b00;
        push(16'h0009);
        lane_take = 2'b11;
        #1;
        chk("rr2_valid", {62'd0, lane_valid}, 64'd2);
        chk("rr2_tag", {30'd0, lane_tag}, {30'd0, 17'h10009, 17'h0});
        chk("rr2_player", lane_player[127:64], 64'hAAAA_0000_0000_0009);
        tick();
        lane_take = 2'b00;
        chk("rr_outstanding", {58'd0, outstanding}, 64'd2);

        // Dummy solve is dropped, then two real solves in one cycle emerge in lane order
        lane_solved = 2'b01;
        lane_otag   = {17'h0, 17'h00033};
        lane_res    = {8'h00, 8'h11};
        tick();
        lane_solved = 2'b11;
        lane_otag   = {17'h10009, 17'h10007};
        lane_res    = {8'hF6, 8'h03};
        tick();
        lane_solved = 2'b00;
        out_ready   = 1'b1;
        wait_out("col_valid0");
        chk("col_id0", {48'd0, out_taskid}, 64'h7);
        chk("col_res0", {56'd0, out_res}, 64'h03);
        tick();
        chk("col_valid1", {63'd0, out_valid}, 64'd1);
        chk("col_id1", {48'd0, out_taskid}, 64'h9);
        chk("col_res1", {56'd0, out_res}, 64'hF6);
        tick();
        chk("col_drained", {63'd0, out_valid}, 64'd0);
        chk("col_outstanding", {58'd0, outstanding}, 64'd0);
        out_ready = 1'b0;

        // Single task: no fall-through, then a later grant and solve of -4
        in_valid    = 1'b1;
        in_taskid   = 16'h0005;
        in_player   = 64'hAAAA_0000_0000_0005;
        in_opponent = 64'h5555_0000_0000_0005;
        lane_take   = 2'b01;
        #1;
        chk("nofall_valid", {62'd0, lane_valid}, 64'd0);
        chk("nofall_tag", {30'd0, lane_tag}, 64'd0);
        tick();
        in_valid  = 1'b0;
        lane_take = 2'b00;
        tick();
        tick();
        lane_take = 2'b01;
        #1;
        chk("one_valid", {62'd0, lane_valid}, 64'd1);
        chk("one_tag", {47'd0, lane_tag[16:0]}, 64'h10005);
        tick();
        lane_take = 2'b00;
        chk("one_outstanding1", {58'd0, outstanding}, 64'd1);
        chk("one_idle_busy", {63'd0, idle}, 64'd0);
        lane_solved = 2'b01;
        lane_otag   = {17'h0, 17'h10005};
        lane_res    = {8'h00, 8'hFC};
        tick();
        lane_solved = 2'b00;
        wait_out("one_out_valid");
        chk("one_out_id", {48'd0, out_taskid}, 64'h5);
        chk("one_out_res", {56'd0, out_res}, 64'hFC);
        tick();
        chk("one_out_stable", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_out_popped", {63'd0, out_valid}, 64'd0);
        chk("one_outstanding0", {58'd0, outstanding}, 64'd0);
        chk("one_idle", {63'd0, idle}, 64'd1);

        // Credit limit: 40 tasks, takes every cycle, consumer stalled
        pushed = 0;
        grants = 0;
        for (int c = 0; c < 80; c++) begin
            in_valid    = (pushed < 40);
            in_taskid   = 16'h0100 + 16'(pushed);
            in_player   = 64'(pushed);
            in_opponent = 64'(pushed);
            lane_take   = 2'b11;
            #1;
            g  = lane_valid;
            tg = lane_tag;
            if (in_valid && in_ready) pushed++;
            grants += $countones(g);
            tick();
            lane_solved = g;
            lane_otag   = tg;
            lane_res    = 16'h0101;
        end
        in_valid  = 1'b0;
        #1;
        chk("credit_pushed", 64'(pushed), 64'd40);
        chk("credit_grants", 64'(grants), 64'd32);
        chk("credit_blocked", {62'd0, lane_valid}, 64'd0);
        chk("credit_outstanding", {58'd0, outstanding}, 64'd32);
        lane_take   = 2'b00;
        lane_solved = 2'b00;
        tick();
        chk("credit_head_id", {48'd0, out_taskid}, 64'h100);
        chk("credit_head_res", {56'd0, out_res}, 64'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("credit_pop_id", {48'd0, out_taskid}, 64'h101);
        chk("credit_after_pop", {58'd0, outstanding}, 64'd31);
        lane_take = 2'b11;
        #1;
        chk("credit_one_more", 64'($countones(lane_valid)), 64'd1);
        tick();
        #1;
        chk("credit_refull", {58'd0, outstanding}, 64'd32);
        chk("credit_blocked2", {62'd0, lane_valid}, 64'd0);
        lane_take = 2'b00;

        // Reset in the middle of a run with tasks still queued
        iRESET = 1'b1;
        tick();
        iRESET = 1'b0;
        chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_outstanding", {58'd0, outstanding}, 64'd0);
        chk("mrst_lane_enable", {62'd0, lane_enable}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
        n = 0;
        while (lane_enable == 2'b00 && n < 20) begin
            n++;
            tick();
        end
        chk("mrst_init_cycles", 64'(n), 64'd8);
        chk("mrst_idle", {63'd0, idle}, 64'd1);
        lane_take = 2'b01;
        #1;
        chk("mrst_fifo_empty", {62'd0, lane_valid}, 64'd0);
        lane_take = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
